// File: rtl/delay_line_meter.sv
// delay_line_meter: round-trip timing of a LUT delay chain in clk cycles.
//
// Drives the chain input with 2-phase transitions on trig_out and waits for the
// chain output (echo_in) to match it. Accumulates 2**LOG2_ITER rounds. Reports
// the sum, the truncated average, and a sticky timeout flag.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   start    in   single-cycle request; only honoured while idle
//   echo_in  in   chain output, asynchronous to clk
//   trig_out out  chain input; toggles once per round
//   busy     out  measurement in progress (ARM/LAUNCH/WAIT)
//   done     out  one-cycle pulse at the end of a measurement
//   timeout  out  a round hit TIMEOUT; held until the next accepted start
//   sum      out  accumulated round counts; valid with done
//   avg      out  sum >> LOG2_ITER
//   rmin     out  smallest completed round value (DELAY_METER_MINMAX_EN only)
//   rmax     out  largest completed round value  (DELAY_METER_MINMAX_EN only)
//
// Optional build macro: DELAY_METER_MINMAX_EN adds the rmin/rmax outputs.
module delay_line_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned LOG2_ITER   = 2,
   parameter int unsigned TIMEOUT     = 1023,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       echo_in,
   output logic                       trig_out,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output logic [CNT_W+LOG2_ITER-1:0] sum,
   output logic [CNT_W-1:0]           avg
`ifdef DELAY_METER_MINMAX_EN
   ,
   output logic [CNT_W-1:0]           rmin,
   output logic [CNT_W-1:0]           rmax
`endif
);

   localparam int unsigned SumW = CNT_W + LOG2_ITER;
   localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StLaunch,
      StWait,
      StFin
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   trig_q, trig_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LOG2_ITER-1:0]   iter_q, iter_d;
   logic                   timeout_q, timeout_d;
   logic [SumW-1:0]        sum_q, sum_d;
`ifdef DELAY_METER_MINMAX_EN
   logic [CNT_W-1:0]       rmin_q, rmin_d;
   logic [CNT_W-1:0]       rmax_q, rmax_d;
`endif

   logic             settled;
   logic             cnt_at_limit;
   logic [CNT_W-1:0] cnt_inc;

   // The chain has finished propagating once the synchronised echo matches the
   // level we last launched.
   assign settled      = (sync_q[SYNC_STAGES-1] == trig_q);
   assign cnt_at_limit = (cnt_q == TimeoutVal);
   assign cnt_inc      = cnt_at_limit ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      trig_d    = trig_q;
      cnt_d     = cnt_q;
      iter_d    = iter_q;
      timeout_d = timeout_q;
      sum_d     = sum_q;
`ifdef DELAY_METER_MINMAX_EN
      rmin_d    = rmin_q;
      rmax_d    = rmax_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StArm;
               cnt_d     = '0;
               iter_d    = '0;
               timeout_d = 1'b0;
               sum_d     = '0;
`ifdef DELAY_METER_MINMAX_EN
               rmin_d    = '1;
               rmax_d    = '0;
`endif
            end
         end
         // Let any earlier activity on the chain die out before launching.
         StArm: begin
            if (settled) begin
               state_d = StLaunch;
            end else if (cnt_at_limit) begin
               timeout_d = 1'b1;
               state_d   = StFin;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StLaunch: begin
            trig_d  = ~trig_q;
            cnt_d   = '0;
            state_d = StWait;
         end
         // Echo is checked before the limit so a round ending exactly at
         // TIMEOUT still counts as completed.
         StWait: begin
            if (settled) begin
               sum_d = sum_q + SumW'(cnt_q);
`ifdef DELAY_METER_MINMAX_EN
               if (cnt_q < rmin_q) rmin_d = cnt_q;
               if (cnt_q > rmax_q) rmax_d = cnt_q;
`endif
               if (&iter_q) begin
                  state_d = StFin;
               end else begin
                  iter_d  = iter_q + 1'b1;
                  state_d = StLaunch;
               end
            end else if (cnt_at_limit) begin
               timeout_d = 1'b1;
               state_d   = StFin;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         trig_q    <= 1'b0;
         cnt_q     <= '0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
         sum_q     <= '0;
`ifdef DELAY_METER_MINMAX_EN
         rmin_q    <= '1;
         rmax_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], echo_in};
         trig_q    <= trig_d;
         cnt_q     <= cnt_d;
         iter_q    <= iter_d;
         timeout_q <= timeout_d;
         sum_q     <= sum_d;
`ifdef DELAY_METER_MINMAX_EN
         rmin_q    <= rmin_d;
         rmax_q    <= rmax_d;
`endif
      end
   end

   assign trig_out = trig_q;
   assign busy     = (state_q == StArm) || (state_q == StLaunch) || (state_q == StWait);
   assign done     = (state_q == StFin);
   assign timeout  = timeout_q;
   assign sum      = sum_q;
   assign avg      = sum_q[SumW-1:LOG2_ITER];
`ifdef DELAY_METER_MINMAX_EN
   assign rmin     = rmin_q;
   assign rmax     = rmax_q;
`endif

endmodule
